mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_wait_cnt.sv | 30 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg : arbiter state encoding and grant identifiers       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_wait_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_wait_cnt : 4-bit loadable down-counter with zero flag            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb_wait_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= 4'd0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign zero_o = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : fetch/data arbiter for a shared single-port memory     |
// | MEM_ARB_RR_EN selects round-robin, otherwise data port has priority. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  import mem_arbiter_pkg::*;

  localparam logic [3:0] c_LOAD = 4'(MEM_LAT - 1);

  state_t r_state;
  logic   r_gnt;
  logic   w_any_req;
  logic   w_win;
  logic   w_load;
  logic   w_dec;
  logic   w_zero;

  assign w_any_req = if_req_i | d_req_i;
  assign w_load    = (r_state == IDLE) && w_any_req;
  assign w_dec     = (r_state == ACCESS);
  assign busy_o    = (r_state != IDLE);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Pointer remembers the last grant; the other port wins a tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last <= GNT_I;
    end else if (w_load) begin
      r_last <= w_win;
    end
  end

  assign w_win = (if_req_i && d_req_i) ? ~r_last : (d_req_i ? GNT_D : GNT_I);
`else
  assign w_win = d_req_i ? GNT_D : GNT_I;
`endif

  arb_wait_cnt u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_load),
    .load_val_i (c_LOAD),
    .dec_i      (w_dec),
    .zero_o     (w_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_I;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt       <= w_win;
            mem_en_o    <= 1'b1;
            mem_we_o    <= (w_win == GNT_D) && d_we_i;
            mem_addr_o  <= (w_win == GNT_D) ? d_addr_i : if_addr_i;
            mem_wdata_o <= (w_win == GNT_D) ? d_wdata_i : '0;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_zero) begin
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            if (!mem_we_o) begin
              if (r_gnt == GNT_D) d_rdata_o  <= mem_rdata_i;
              else                if_rdata_o <= mem_rdata_i;
            end
            if (r_gnt == GNT_D) d_ack_o  <= 1'b1;
            else                if_ack_o <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : self-checking bench with a transaction-timing model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy;

  logic        l_req = 1'b0;
  logic        l_zero = 1'b0;
  logic [31:0] l_addr = 32'h40;
  logic [31:0] l_zd = '0;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_busy;
  logic [31:0] l15_if_rdata, l15_d_rdata, l15_mem_addr, l15_mem_wdata, l15_mem_rdata;
  logic        l15_if_ack, l15_d_ack, l15_mem_en, l15_mem_we, l15_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h2010_0015;
  endfunction

  assign mem_rdata     = memf(mem_addr);
  assign l1_mem_rdata  = memf(l1_mem_addr);
  assign l15_mem_rdata = memf(l15_mem_addr);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(l_req), .if_addr_i(l_addr), .if_rdata_o(l1_if_rdata), .if_ack_o(l1_if_ack),
    .d_req_i(l_zero), .d_we_i(l_zero), .d_addr_i(l_zd), .d_wdata_i(l_zd),
    .d_rdata_o(l1_d_rdata), .d_ack_o(l1_d_ack),
    .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
    .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata), .busy_o(l1_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut15 (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(l_req), .if_addr_i(l_addr), .if_rdata_o(l15_if_rdata), .if_ack_o(l15_if_ack),
    .d_req_i(l_zero), .d_we_i(l_zero), .d_addr_i(l_zd), .d_wdata_i(l_zd),
    .d_rdata_o(l15_d_rdata), .d_ack_o(l15_d_ack),
    .mem_en_o(l15_mem_en), .mem_we_o(l15_mem_we), .mem_addr_o(l15_mem_addr),
    .mem_wdata_o(l15_mem_wdata), .mem_rdata_i(l15_mem_rdata), .busy_o(l15_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction timeline: a grant at edge t keeps memory enabled until
  // edge t+LAT, acks in the cycle after it, and frees the port one edge later.
  int          edge_n = 0, t_start = 0;
  bit          m_act = 0, m_wd = 0, m_we = 0, m_last_d = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_d_rd = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_n = 0; t_start = 0; m_act = 0; m_wd = 0; m_we = 0; m_last_d = 0;
        m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
      end else begin
        edge_n++;
        if (m_act) begin
          if (edge_n - t_start == LAT) begin
            if (!m_we) begin
              if (m_wd) m_d_rd  = memf(m_addr);
              else      m_if_rd = memf(m_addr);
            end
          end else if (edge_n - t_start == LAT + 1) begin
            m_act = 0;
          end
        end else if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
          m_wd = (if_req && d_req) ? !m_last_d : d_req;
`else
          m_wd = d_req;
`endif
          m_last_d = m_wd;
          m_act    = 1;
          t_start  = edge_n;
          m_we     = m_wd && d_we;
          m_addr   = m_wd ? d_addr : if_addr;
          m_wdata  = d_wdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        int  rel;
        bit  e_en, e_resp;
        rel    = edge_n - t_start;
        e_en   = m_act && (rel < LAT);
        e_resp = m_act && (rel == LAT);
        check("busy",     {31'b0, busy},   {31'b0, m_act});
        check("mem_en",   {31'b0, mem_en}, {31'b0, e_en});
        check("if_ack",   {31'b0, if_ack}, {31'b0, e_resp && !m_wd});
        check("d_ack",    {31'b0, d_ack},  {31'b0, e_resp && m_wd});
        check("if_rdata", if_rdata, m_if_rd);
        check("d_rdata",  d_rdata,  m_d_rd);
        check("mem_addr", mem_addr, m_addr);
        if (e_en) check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        if (e_en && m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  task automatic wait_ack(input bit dport, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dport ? d_ack : if_ack) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL ack_timeout: got no ack want ack within 40 cycles");
  endtask

  task automatic req_i(input logic [31:0] a, output int lat);
    @(posedge clk); #2;
    if_addr = a; if_req = 1'b1;
    wait_ack(1'b0, lat);
    @(posedge clk); #2;
    if_req = 1'b0;
  endtask

  task automatic req_d(input bit we, input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(posedge clk); #2;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_ack(1'b1, lat);
    @(posedge clk); #2;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic wait_l(input bit fifteen, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (fifteen ? l15_if_ack : l1_if_ack) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL lat_timeout: got no ack want ack within 40 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_i, lat_d, cnt, n_ack, l1, l15;
    logic [3:0] ord;

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_en",   {31'b0, mem_en}, 32'd0);
    check("rst_rd",   if_rdata | d_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single fetch
    req_i(32'h0000_0010, lat_i);
    check("if_lat", lat_i, 32'd3);
    check("if_rdata_lit", if_rdata, 32'h2010_0005);

    // data read then write; write must not touch rdata
    req_d(1'b0, 32'h8, 32'h0, lat_d);
    check("d_rd_lit", d_rdata, 32'h2010_001D);
    cnt = 0;
    fork
      req_d(1'b1, 32'h4, 32'hDEAD_BEEF, lat_d);
      repeat (8) begin
        @(negedge clk);
        if (mem_en && mem_we && mem_addr == 32'h4 && mem_wdata == 32'hDEAD_BEEF) cnt++;
      end
    join
    check("wr_cycles", cnt, 32'd2);
    check("wr_lat", lat_d, 32'd3);
    check("wr_keep_rd", d_rdata, 32'h2010_001D);

    // simultaneous requests
    fork
      req_d(1'b0, 32'h100, 32'h0, lat_d);
      req_i(32'h200, lat_i);
    join
`ifdef MEM_ARB_RR_EN
    check("sim_i_lat", lat_i, 32'd3);
    check("sim_d_lat", lat_d, 32'd7);
`else
    check("sim_d_lat", lat_d, 32'd3);
    check("sim_i_lat", lat_i, 32'd7);
`endif
    check("sim_d_rd", d_rdata, 32'h2010_0115);
    check("sim_i_rd", if_rdata, 32'h2010_0215);

    // fetch-only grant leaves the pointer at instruction
    req_i(32'h30, lat_i);
    check("if2_rd", if_rdata, 32'h2010_0025);

    // both held high across four transactions
    @(posedge clk); #2;
    d_we = 1'b0; d_addr = 32'h44; if_addr = 32'h48; d_req = 1'b1; if_req = 1'b1;
    n_ack = 0; ord = '0;
    for (int i = 0; i < 60 && n_ack < 4; i++) begin
      @(negedge clk);
      if (d_ack || if_ack) begin
        ord = {ord[2:0], d_ack};
        n_ack++;
      end
    end
    @(posedge clk); #2;
    d_req = 1'b0; if_req = 1'b0;
    check("held_acks", n_ack, 32'd4);
`ifdef MEM_ARB_RR_EN
    check("held_order", {28'b0, ord}, 32'hA);
`else
    check("held_order", {28'b0, ord}, 32'hF);
`endif

    // reset in the middle of a data read
    @(posedge clk); #2;
    d_we = 1'b0; d_addr = 32'h60; d_req = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_en", {31'b0, mem_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_en", {31'b0, mem_en | mem_we | d_ack | if_ack}, 32'd0);
    check("rst_mid_addr", mem_addr | mem_wdata, 32'd0);
    check("rst_mid_rd", if_rdata | d_rdata, 32'd0);
    d_req = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack) cnt++;
    end
    check("no_ack_after_rst", cnt, 32'd0);
    req_d(1'b0, 32'h70, 32'h0, lat_d);
    check("post_rst_lat", lat_d, 32'd3);
    check("post_rst_rd", d_rdata, 32'h2010_0065);

    // latency at the parameter extremes
    @(posedge clk); #2 l_req = 1'b1;
    fork
      wait_l(1'b0, l1);
      wait_l(1'b1, l15);
    join
    @(posedge clk); #2 l_req = 1'b0;
    check("lat1", l1, 32'd2);
    check("lat15", l15, 32'd16);
    check("lat15_rd", l15_if_rdata, 32'h2010_0055);

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
